// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Width of the response-wait counter; never narrower than one bit.
    function automatic int tmo_ctr_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Response-wait counter: cleared on command accept, counts while a transaction is in flight.
// o_expired fires on the cycle whose edge brings the count to TIMEOUT_CYCLES-1.
module axil_timeout_ctr
    import axil_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW   = tmo_ctr_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Outputs are registered downstream, so decide one count early.
    assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// One-outstanding register command -> AXI4-Lite master; cmd handshake to rsp_valid is 3 cycles with a zero-wait slave.
// cmd_ready stays low until the response is consumed. Optional response timeout: AXIL_MASTER_TIMEOUT_EN.
module axil_cmd_master
    import axil_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_t                    r_state;
    state_t                    w_nxt_state;
    logic                      r_cmd_ready;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_rsp_valid;
    logic                      r_resp_rdy;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [1:0]                r_rsp_resp;

    logic w_awvalid;
    logic w_wvalid;
    logic w_arvalid;
    logic w_rsp_valid;
    logic w_cmd_acc;
    logic w_cap_b;
    logic w_cap_r;
    logic w_tmo_fire;
    logic w_expired;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic w_busy;
    logic r_rsp_timeout;

    assign w_busy = (r_state == ST_WR) || (r_state == ST_WR_RESP) ||
                    (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_clear   (w_cmd_acc),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_tmo_fire) begin
            r_rsp_timeout <= 1'b1;
        end else if (w_cap_b || w_cap_r) begin
            r_rsp_timeout <= 1'b0;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_expired   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_arvalid   = r_arvalid;
        w_rsp_valid = r_rsp_valid;
        w_cmd_acc   = 1'b0;
        w_cap_b     = 1'b0;
        w_cap_r     = 1'b0;
        w_tmo_fire  = 1'b0;
        if (w_expired) begin
            w_tmo_fire  = 1'b1;
            w_awvalid   = 1'b0;
            w_wvalid    = 1'b0;
            w_arvalid   = 1'b0;
            w_rsp_valid = 1'b1;
            w_nxt_state = ST_RSP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        w_cmd_acc = 1'b1;
                        if (cmd_rnw) begin
                            w_arvalid   = 1'b1;
                            w_nxt_state = ST_RD_ADDR;
                        end else begin
                            w_awvalid   = 1'b1;
                            w_wvalid    = 1'b1;
                            w_nxt_state = ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W retire independently, in either order.
                    if (M_AXI_AWREADY) w_awvalid = 1'b0;
                    if (M_AXI_WREADY)  w_wvalid  = 1'b0;
                    if (!w_awvalid && !w_wvalid) w_nxt_state = ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        w_cap_b     = 1'b1;
                        w_rsp_valid = 1'b1;
                        w_nxt_state = ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        w_arvalid   = 1'b0;
                        w_nxt_state = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        w_cap_r     = 1'b1;
                        w_rsp_valid = 1'b1;
                        w_nxt_state = ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        w_rsp_valid = 1'b0;
                        w_nxt_state = ST_IDLE;
                    end
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_resp_rdy  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cmd_ready <= (w_nxt_state == ST_IDLE);
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_arvalid   <= w_arvalid;
            r_rsp_valid <= w_rsp_valid;
            r_resp_rdy  <= 1'b1;
        end
    end

    // B/R beats are always accepted; ones that arrive outside WR_RESP/RD_DATA are dropped.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            if (w_cmd_acc) begin
                r_addr  <= cmd_addr & ADDR_ALIGN_MASK;
                r_wdata <= cmd_wdata;
                r_wstrb <= cmd_wstrb;
            end
            if (w_cap_b) begin
                r_rsp_rdata <= '0;
                r_rsp_resp  <= M_AXI_BRESP;
            end else if (w_cap_r) begin
                r_rsp_rdata <= M_AXI_RDATA;
                r_rsp_resp  <= M_AXI_RRESP;
            end else if (w_tmo_fire) begin
                r_rsp_rdata <= '0;
                r_rsp_resp  <= AXI_RESP_OKAY;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_resp_rdy;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_resp_rdy;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: memory-backed AXI4-Lite slave with per-channel delays plus a word-array reference model.
module tb_axil_cmd_master;
    import axil_master_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;
    localparam logic [AW-1:0] REG_RWS_ADDR = 32'h0000_0010;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_rnw = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [SW-1:0]   cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY = 1'b0;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [SW-1:0]   M_AXI_WSTRB;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY = 1'b0;
    logic [1:0]      M_AXI_BRESP = 2'b00;
    logic            M_AXI_BVALID = 1'b0;
    logic            M_AXI_BREADY;
    logic [AW-1:0]   M_AXI_ARADDR;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY = 1'b0;
    logic [DW-1:0]   M_AXI_RDATA = '0;
    logic [1:0]      M_AXI_RRESP = 2'b00;
    logic            M_AXI_RVALID = 1'b0;
    logic            M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axil_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rnw (cmd_rnw),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout),
        .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB), .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY), .M_AXI_BRESP (M_AXI_BRESP), .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY), .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY), .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID), .M_AXI_RREADY (M_AXI_RREADY)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and state.
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit         ar_never = 0, stray_b = 0;
    logic [1:0] b_resp_cfg = AXI_RESP_OKAY, r_resp_cfg = AXI_RESP_OKAY;
    logic [31:0] smem [0:63];
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    int         b_beats = 0;

    bit have_aw = 0, have_w = 0, have_ar = 0;
    bit hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
    logic [AW-1:0] aw_addr_c = '0, ar_addr_c = '0;
    logic [DW-1:0] w_data_c = '0;
    logic [SW-1:0] w_strb_c = '0;
    int cnt_aw = 0, cnt_w = 0, cnt_b = 0, cnt_ar = 0, cnt_r = 0;

    // Reference model: word array, byte strobes merged with a mask.
    logic [31:0] ref_mem [0:63];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++)
            if (strb[i]) mask = mask | (32'hFF << (8 * i));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    always @(negedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0;  M_AXI_RVALID = 0;
            have_aw = 0; have_w = 0; have_ar = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0;
        end else begin
            if (hs_aw) begin have_aw = 1; M_AXI_AWREADY = 0; cnt_aw = 0; end
            if (hs_w)  begin have_w = 1;  M_AXI_WREADY = 0;  cnt_w = 0;  end
            if (hs_ar) begin have_ar = 1; M_AXI_ARREADY = 0; cnt_ar = 0; end
            if (hs_b)  M_AXI_BVALID = 0;
            if (hs_r)  M_AXI_RVALID = 0;
            if (have_aw && have_w && !M_AXI_BVALID) begin
                if (cnt_b < b_dly) cnt_b++;
                else begin
                    for (int i = 0; i < SW; i++)
                        if (w_strb_c[i]) smem[aw_addr_c[7:2]][8*i +: 8] = w_data_c[8*i +: 8];
                    M_AXI_BVALID = 1; M_AXI_BRESP = b_resp_cfg;
                    have_aw = 0; have_w = 0; cnt_b = 0; b_beats++;
                end
            end else if (stray_b && !M_AXI_BVALID) begin
                M_AXI_BVALID = 1; M_AXI_BRESP = AXI_RESP_DECERR; stray_b = 0;
            end
            if (have_ar && !M_AXI_RVALID) begin
                if (cnt_r < r_dly) cnt_r++;
                else begin
                    M_AXI_RDATA = smem[ar_addr_c[7:2]]; M_AXI_RRESP = r_resp_cfg;
                    M_AXI_RVALID = 1; have_ar = 0; cnt_r = 0;
                end
            end
            if (M_AXI_AWVALID && !M_AXI_AWREADY && !have_aw) begin
                if (cnt_aw < aw_dly) cnt_aw++; else M_AXI_AWREADY = 1;
            end
            if (M_AXI_WVALID && !M_AXI_WREADY && !have_w) begin
                if (cnt_w < w_dly) cnt_w++; else M_AXI_WREADY = 1;
            end
            if (M_AXI_ARVALID && !M_AXI_ARREADY && !have_ar && !ar_never) begin
                if (cnt_ar < ar_dly) cnt_ar++; else M_AXI_ARREADY = 1;
            end
            hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            hs_w  = M_AXI_WVALID && M_AXI_WREADY;
            hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            hs_b  = M_AXI_BVALID && M_AXI_BREADY;
            hs_r  = M_AXI_RVALID && M_AXI_RREADY;
            if (hs_aw) begin aw_addr_c = M_AXI_AWADDR; last_awaddr = M_AXI_AWADDR; end
            if (hs_w)  begin w_data_c = M_AXI_WDATA; w_strb_c = M_AXI_WSTRB; end
            if (hs_ar) begin ar_addr_c = M_AXI_ARADDR; last_araddr = M_AXI_ARADDR; end
        end
    end

    task automatic send_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        int w;
        w = 0;
        @(negedge ACLK);
        while (!cmd_ready && w < 100) begin @(negedge ACLK); w++; end
        if (!cmd_ready) check_eq("cmd_ready_wait", 0, 1);
        cmd_valid = 1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge ACLK); #1;
        cmd_valid = 0;
    endtask

    // Cycle 1 is the one right after the command handshake edge.
    task automatic expect_rsp(input string tag, input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                              input logic exp_tmo, input bit chk_lat, input int hold);
        int cyc;
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin @(posedge ACLK); #1; cyc++; end
        if (!rsp_valid) begin
            check_eq({tag, "_rsp_wait"}, 0, 1);
            return;
        end
        if (chk_lat) check_eq({tag, "_latency"}, cyc, 3);
        check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, "_resp"}, rsp_resp, exp_resp);
        check_eq({tag, "_timeout"}, rsp_timeout, exp_tmo);
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            check_eq({tag, "_hold_valid"}, rsp_valid, 1);
            check_eq({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check_eq({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        rsp_ready = 1;
        @(posedge ACLK); #1;
        rsp_ready = 0;
        check_eq({tag, "_rsp_cleared"}, rsp_valid, 0);
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input bit chk_lat, input int hold);
        send_cmd(0, a, d, s);
        expect_rsp(tag, '0, b_resp_cfg, 0, chk_lat, hold);
        ref_mem[a[7:2]] = merge_bytes(ref_mem[a[7:2]], d, s);
        check_eq({tag, "_awaddr"}, last_awaddr, {a[AW-1:2], 2'b00});
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input bit chk_lat, input int hold);
        send_cmd(1, a, '0, '0);
        expect_rsp(tag, ref_mem[a[7:2]], r_resp_cfg, 0, chk_lat, hold);
        check_eq({tag, "_araddr"}, last_araddr, {a[AW-1:2], 2'b00});
    endtask

    task automatic zero_wait();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        b_resp_cfg = AXI_RESP_OKAY; r_resp_cfg = AXI_RESP_OKAY;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        bit seen;
        logic [1:0] rsp_pick [0:2];
        rsp_pick[0] = AXI_RESP_OKAY; rsp_pick[1] = AXI_RESP_SLVERR; rsp_pick[2] = AXI_RESP_DECERR;
        for (int i = 0; i < 64; i++) begin smem[i] = '0; ref_mem[i] = '0; end

        // Reset state
        #22;
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        check_eq("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
        @(negedge ACLK); ARESET = 0;
        @(posedge ACLK); #1;
        check_eq("post_rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 2'b11);
        check_eq("post_rst_cmd_ready", cmd_ready, 1);

        // Write/read-back through the zero-wait slave
        zero_wait();
        do_write("t1_wr", REG_RWS_ADDR, 32'hDEADBEEF, 4'hF, 1, 0);
        do_read("t1_rd", REG_RWS_ADDR, 1, 0);
        check_eq("t1_value", ref_mem[REG_RWS_ADDR[7:2]], 32'hDEADBEEF);

        // AW accepted three cycles before W
        aw_dly = 0; w_dly = 3; nb = b_beats;
        send_cmd(0, 32'h24, 32'hA5A5_0F0F, 4'hF);
        check_eq("t2_c1_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        @(posedge ACLK); #1;
        check_eq("t2_c2_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b01);
        @(posedge ACLK); #1; @(posedge ACLK); #1;
        check_eq("t2_c4_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b01);
        check_eq("t2_c4_wdata", M_AXI_WDATA, 32'hA5A5_0F0F);
        expect_rsp("t2", '0, AXI_RESP_OKAY, 0, 0, 0);
        ref_mem[6'h09] = 32'hA5A5_0F0F;
        check_eq("t2_b_beats", b_beats - nb, 1);
        zero_wait();

        // Partial strobes
        do_write("t3_wr_full", 32'h30, 32'hFFFF_FFFF, 4'hF, 1, 0);
        do_write("t3_wr_low", 32'h33, 32'h1234_5678, 4'b0011, 1, 0);
        do_read("t3_rd", 32'h30, 1, 0);
        check_eq("t3_value", ref_mem[6'h0C], 32'hFFFF_5678);

        // Slave error response and response backpressure
        b_resp_cfg = AXI_RESP_SLVERR;
        do_write("t4_slverr", 32'h40, 32'h0BAD_F00D, 4'hF, 1, 0);
        zero_wait();
        do_read("t4b_hold", 32'h40, 1, 5);

        // Reset while W is stalled
        w_dly = 50;
        send_cmd(0, 32'h50, 32'h5555_AAAA, 4'hF);
        @(posedge ACLK); #2;
        ARESET = 1;
        #1;
        check_eq("t5_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        check_eq("t5_cmd_ready", cmd_ready, 0);
        zero_wait();
        @(posedge ACLK); #2;
        ARESET = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(posedge ACLK); #1; if (rsp_valid) seen = 1; end
        check_eq("t5_no_rsp", seen, 0);
        do_write("t5_after_wr", 32'h54, 32'h0102_0304, 4'hF, 1, 0);
        do_read("t5_lost_rd", 32'h50, 1, 0);

        // Stray B beat while idle
        stray_b = 1; seen = 0;
        for (int i = 0; i < 5; i++) begin @(posedge ACLK); #1; if (rsp_valid) seen = 1; end
        check_eq("stray_b_no_rsp", seen, 0);
        do_read("stray_after_rd", 32'h54, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            logic          rnw;
            int            hold;
            a = AW'($urandom_range(0, 255));
            rnw = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            b_resp_cfg = rsp_pick[$urandom_range(0, 2)];
            r_resp_cfg = rsp_pick[$urandom_range(0, 2)];
            if (rnw)
                do_read("rnd_rd", a, (ar_dly == 0 && r_dly == 0), hold);
            else
                do_write("rnd_wr", a, $urandom, SW'($urandom_range(0, 15)),
                         (aw_dly == 0 && w_dly == 0 && b_dly == 0), hold);
        end
        zero_wait();

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Read address never accepted: give up at cycle 16
        begin
            int cyc;
            ar_never = 1;
            send_cmd(1, 32'h60, '0, '0);
            cyc = 1;
            while (cyc < 15) begin @(posedge ACLK); #1; cyc++; end
            check_eq("t6_c15_arvalid", M_AXI_ARVALID, 1);
            check_eq("t6_c15_rsp_valid", rsp_valid, 0);
            @(posedge ACLK); #1;
            check_eq("t6_c16_arvalid", M_AXI_ARVALID, 0);
            check_eq("t6_c16_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1100);
            ar_never = 0;
            expect_rsp("t6", '0, AXI_RESP_OKAY, 1, 0, 0);
            do_read("t6_after_rd", REG_RWS_ADDR, 1, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
